// File: rtl/psum_collect_fifo_pkg.sv
// Shared constants and helpers for the partial-sum collection FIFO.
package psum_collect_fifo_pkg;

  localparam int unsigned COL_DEFAULT        = 8;
  localparam int unsigned BW_PSUM_DEFAULT    = 20;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

  // Pointer width carries one extra wrap bit so full and empty can be told apart
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/psum_col_buf.sv
// One column's circular psum buffer: private write pointer, read pointer shared with its siblings.
module psum_col_buf
  import psum_collect_fifo_pkg::*;
#(
  parameter int unsigned bw_psum = BW_PSUM_DEFAULT,
  parameter int unsigned depth   = FIFO_DEPTH_DEFAULT,
  parameter int unsigned ptr_w   = ptr_width(FIFO_DEPTH_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [bw_psum-1:0] din,
  input  logic [ptr_w-1:0]   rdptr,
  output logic               empty,
  output logic               full,
  output logic [bw_psum-1:0] dout
);

  localparam int unsigned AW = ptr_w - 1;

  logic [ptr_w-1:0]   r_wrptr;
  logic [bw_psum-1:0] r_mem [depth];
  logic               w_push;

  assign empty  = (r_wrptr == rdptr);
  assign full   = (r_wrptr[AW-1:0] == rdptr[AW-1:0]) && (r_wrptr[AW] != rdptr[AW]);
  assign w_push = wr & ~full;
  assign dout   = r_mem[rdptr[AW-1:0]];

  // Advance the write pointer on every accepted write; a full column holds it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrptr <= '0;
    end else if (w_push) begin
      r_wrptr <= r_wrptr + ptr_w'(1);
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/psum_collect_fifo.sv
// Collects staggered per-column psums and releases aligned rows once every column has data.
// Optional feature: define PSUM_RELU_EN to clamp negative psums to zero at the output register.
module psum_collect_fifo
  import psum_collect_fifo_pkg::*;
#(
  parameter int unsigned col     = COL_DEFAULT,
  parameter int unsigned bw_psum = BW_PSUM_DEFAULT,
  parameter int unsigned depth   = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr,
  input  logic [col*bw_psum-1:0]   in,
  input  logic                     rd,
  output logic [col*bw_psum-1:0]   out,
  output logic                     out_valid,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     overflow
);

  localparam int unsigned PTR_W = ptr_width(depth);

  logic [PTR_W-1:0]       r_rdptr;
  logic [col*bw_psum-1:0] r_out;
  logic                   r_out_valid;
  logic                   r_overflow;

  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [col*bw_psum-1:0] w_dout;
  logic [col*bw_psum-1:0] w_row;
  logic                   w_pop;
  logic                   w_drop;

  for (genvar g = 0; g < col; g++) begin : g_col
    psum_col_buf #(
      .bw_psum (bw_psum),
      .depth   (depth),
      .ptr_w   (PTR_W)
    ) u_col_buf (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .din   (in[g*bw_psum +: bw_psum]),
      .rdptr (r_rdptr),
      .empty (w_empty[g]),
      .full  (w_full[g]),
      .dout  (w_dout[g*bw_psum +: bw_psum])
    );
  end

  // Flags come straight from pointers, so a same-cycle write is not visible until next cycle
  assign o_valid = ~|w_empty;
  assign o_full  = |w_full;
  assign w_pop   = rd & o_valid;
  assign w_drop  = |(wr & w_full);

  // Row presented to the output register, optionally clamped at zero
  always_comb begin
    w_row = w_dout;
`ifdef PSUM_RELU_EN
    for (int unsigned i = 0; i < col; i++) begin
      if (w_dout[i*bw_psum + bw_psum - 1]) begin
        w_row[i*bw_psum +: bw_psum] = '0;
      end
    end
`endif
  end

  // Shared read pointer, output row register, pop pulse and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdptr     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_rdptr <= r_rdptr + PTR_W'(1);
        r_out   <= w_row;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_psum_collect_fifo.sv
// Self-checking bench for psum_collect_fifo against a queue-based row model.
module tb_psum_collect_fifo;

  localparam int unsigned COL   = 8;
  localparam int unsigned BW    = 20;
  localparam int unsigned DEPTH = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [COL-1:0]      wr;
  logic [COL*BW-1:0]   in_v;
  logic                rd;
  logic [COL*BW-1:0]   out;
  logic                out_valid;
  logic                o_valid;
  logic                o_full;
  logic                overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per column, popped row, pop pulse, sticky overflow
  logic [BW-1:0]     mq [COL][$];
  logic [COL*BW-1:0] m_out;
  logic              m_out_valid;
  logic              m_ovf;

  psum_collect_fifo #(
    .col     (COL),
    .bw_psum (BW),
    .depth   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (in_v),
    .rd        (rd),
    .out       (out),
    .out_valid (out_valid),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef PSUM_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic model_valid();
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < COL; i++) if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [BW-1:0] slice(input logic [COL*BW-1:0] v, input int i);
    return v[i*BW +: BW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < COL; i++) mq[i].delete();
    m_out       = '0;
    m_out_valid = 1'b0;
    m_ovf       = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, return at edge+1
  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    logic           vld;
    logic [COL-1:0] fl;
    wr   = w;
    in_v = d;
    rd   = r;
    @(posedge clk);
    vld = model_valid();
    for (int i = 0; i < COL; i++) fl[i] = (mq[i].size() == DEPTH);
    m_out_valid = r && vld;
    if (r && vld) begin
      for (int i = 0; i < COL; i++) m_out[i*BW +: BW] = relu(mq[i].pop_front());
    end
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (fl[i]) m_ovf = 1'b1;
        else mq[i].push_back(d[i*BW +: BW]);
      end
    end
    #1;
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    model_clear();
    #2 reset = 1'b1;
  endtask

  function automatic logic [COL*BW-1:0] rand_row();
    logic [COL*BW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  function automatic logic [COL*BW-1:0] const_row(input int base, input int stride);
    logic [COL*BW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'(base + stride * i);
    return v;
  endfunction

  task automatic test_reset();
    // Reset held low from time 0
    if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
    n_checks++;
    if (o_full !== 1'b0) begin n_errors++; $display("FAIL reset_o_full got=%b exp=0", o_full); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (out !== '0) begin n_errors++; $display("FAIL reset_out got=%h exp=0", out); end
    n_checks++;
    #1 reset = 1'b1;
    for (int r = 0; r < 3; r++) step('1, rand_row(), 1'b0);
    step('0, '0, 1'b1);
    if (out_valid !== 1'b1 || out !== m_out) begin
      n_errors++; $display("FAIL pre_reset_pop got=%b/%h exp=1/%h", out_valid, out, m_out);
    end
    n_checks++;
    // Mid-cycle asynchronous reset
    #2 reset = 1'b0;
    #1;
    if (o_valid !== 1'b0 || out !== '0 || out_valid !== 1'b0 || o_full !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got v=%b out=%h ov=%b f=%b exp all 0", o_valid, out, out_valid,
               o_full);
    end
    n_checks++;
    model_clear();
    #2 reset = 1'b1;
    step('0, '0, 1'b1);
    if (out_valid !== 1'b0 || out !== '0 || o_valid !== 1'b0) begin
      n_errors++; $display("FAIL rd_after_reset got ov=%b out=%h v=%b exp 0", out_valid, out, o_valid);
    end
    n_checks++;
  endtask

  task automatic test_staggered();
    logic [COL*BW-1:0] d;
    do_reset();
    d = const_row(100, 1);
    for (int i = 0; i < COL; i++) begin
      step(COL'(1) << i, d, 1'b0);
      if (o_valid !== (i == COL - 1)) begin
        n_errors++; $display("FAIL stagger_valid col=%0d got=%b exp=%b", i, o_valid, i == COL - 1);
      end
      n_checks++;
    end
    step('0, '0, 1'b1);
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stagger_pop got=%b exp=1", out_valid); end
    n_checks++;
    for (int i = 0; i < COL; i++) begin
      if (slice(out, i) !== BW'(100 + i)) begin
        n_errors++; $display("FAIL stagger_out col=%0d got=%0d exp=%0d", i, slice(out, i), 100 + i);
      end
      n_checks++;
    end
    step('0, '0, 1'b0);
    if (out_valid !== 1'b0 || slice(out, 3) !== BW'(103)) begin
      n_errors++; $display("FAIL stagger_hold got=%b/%0d exp=0/103", out_valid, slice(out, 3));
    end
    n_checks++;
  endtask

  task automatic test_full_overflow();
    logic [BW-1:0] saved [DEPTH];
    logic [COL*BW-1:0] d;
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      d = rand_row();
      saved[k] = slice(d, 0);
      step(COL'(1), d, 1'b0);
    end
    if (o_full !== 1'b1 || o_valid !== 1'b0 || overflow !== 1'b0) begin
      n_errors++; $display("FAIL col0_full got f=%b v=%b o=%b exp 1/0/0", o_full, o_valid, overflow);
    end
    n_checks++;
    step(COL'(1), const_row(20'hABCDE, 0), 1'b0);
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    n_checks++;
    for (int k = 0; k < DEPTH; k++) step({{(COL-1){1'b1}}, 1'b0}, rand_row(), 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      step('0, '0, 1'b1);
      if (out_valid !== 1'b1 || slice(out, 0) !== relu(saved[k])) begin
        n_errors++;
        $display("FAIL col0_drain k=%0d got=%b/%h exp=1/%h", k, out_valid, slice(out, 0),
                 relu(saved[k]));
      end
      n_checks++;
    end
    if (o_valid !== 1'b0 || overflow !== 1'b1) begin
      n_errors++; $display("FAIL after_drain got v=%b o=%b exp 0/1", o_valid, overflow);
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    int n_pop = 0;
    do_reset();
    for (int r = 0; r < 40 + DEPTH; r++) begin
      if (r < 40) step('1, const_row(r, 0), (r % 4) != 0);
      else step('0, '0, 1'b1);
      if (out_valid !== m_out_valid) begin
        n_errors++; $display("FAIL wrap_pulse r=%0d got=%b exp=%b", r, out_valid, m_out_valid);
      end
      n_checks++;
      if (m_out_valid) begin
        if (out !== const_row(n_pop, 0)) begin
          n_errors++; $display("FAIL wrap_row got=%h exp row %0d", out, n_pop);
        end
        n_checks++;
        n_pop++;
      end
    end
    if (n_pop !== 40 || overflow !== 1'b0 || o_valid !== 1'b0) begin
      n_errors++; $display("FAIL wrap_end got pops=%0d o=%b v=%b exp 40/0/0", n_pop, overflow, o_valid);
    end
    n_checks++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    step('1, rand_row(), 1'b0);
    for (int k = 1; k < DEPTH; k++) step(COL'(1), rand_row(), 1'b0);
    if (o_full !== 1'b1 || o_valid !== 1'b1) begin
      n_errors++; $display("FAIL sim_setup got f=%b v=%b exp 1/1", o_full, o_valid);
    end
    n_checks++;
    step(COL'(1), rand_row(), 1'b1);
    if (out_valid !== 1'b1 || overflow !== 1'b1 || o_full !== 1'b0 || out !== m_out) begin
      n_errors++;
      $display("FAIL sim_full got ov=%b o=%b f=%b exp 1/1/0", out_valid, overflow, o_full);
    end
    n_checks++;
    step({{(COL-1){1'b1}}, 1'b0}, rand_row(), 1'b0);
    step(COL'(1), rand_row(), 1'b1);
    if (out_valid !== 1'b1 || o_full !== 1'b0 || out !== m_out) begin
      n_errors++; $display("FAIL sim_15 got ov=%b f=%b exp 1/0", out_valid, o_full);
    end
    n_checks++;
    step(COL'(1), rand_row(), 1'b0);
    if (o_full !== 1'b1) begin n_errors++; $display("FAIL sim_refill got=%b exp=1", o_full); end
    n_checks++;
  endtask

  task automatic test_relu();
    logic [COL*BW-1:0] d;
    logic [BW-1:0]     exp0;
    do_reset();
    d = rand_row();
    d[0 +: BW]  = -BW'(5);
    d[BW +: BW] = BW'(7);
`ifdef PSUM_RELU_EN
    exp0 = '0;
`else
    exp0 = -BW'(5);
`endif
    step('1, d, 1'b0);
    step('0, '0, 1'b1);
    if (slice(out, 0) !== exp0 || slice(out, 1) !== BW'(7)) begin
      n_errors++;
      $display("FAIL relu got=%h,%h exp=%h,%h", slice(out, 0), slice(out, 1), exp0, BW'(7));
    end
    n_checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(COL'($urandom), rand_row(), 1'($urandom));
      if (out_valid !== m_out_valid || o_valid !== model_valid() || o_full !== model_full() ||
          overflow !== m_ovf || out !== m_out) begin
        n_errors++;
        $display("FAIL random c=%0d got ov=%b v=%b f=%b o=%b out=%h exp %b %b %b %b %h", c,
                 out_valid, o_valid, o_full, overflow, out, m_out_valid, model_valid(),
                 model_full(), m_ovf, m_out);
      end
      n_checks++;
    end
  endtask

  initial begin
    reset = 1'b0;
    wr    = '0;
    in_v  = '0;
    rd    = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_staggered();
    test_full_overflow();
    test_wrap();
    test_simultaneous();
    test_relu();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_collect_fifo.md
Name: psum_collect_fifo

Overview:
- Receiving end of the MAC-column output interface: captures each column's signed partial sum when that column pulses its write strobe.
- Columns fire staggered by one cycle each, because the instruction ripples column to column. The block therefore buffers per column.
- It releases a full aligned row (one psum per column) to the downstream special-function / readout stage only when every column has data.

Parameters:
- col, 8, number of MAC columns feeding the block
- bw_psum, 20, width of one signed partial sum
- depth, 16, entries per column buffer; must be a power of 2, minimum 2

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; state clears immediately while reset is 0
- wr  input  col  per-column write strobe; bit i is column i's fifo_wr
- in  input  col*bw_psum  per-column psum; slice i = in[(i+1)*bw_psum-1 : i*bw_psum]
- rd  input  1  downstream pop request
- out  output  col*bw_psum  registered row of psums, same slice order as in
- out_valid  output  1  one-cycle pulse: out holds a newly popped row
- o_valid  output  1  all columns non-empty; a row can be popped
- o_full  output  1  at least one column buffer is full
- overflow  output  1  sticky: a write was dropped because its column was full

Behaviour:
- Reset (reset=0, asynchronous): all write pointers, the read pointer and all counts go to 0. out=0, out_valid=0, o_valid=0, o_full=0, overflow=0. Buffer contents are don't-care. Assertion mid-operation discards all stored data immediately.
- Storage: one circular buffer per column, each with its own write pointer of log2(depth)+1 bits (extra wrap bit). A single read pointer is shared, because rows are always popped together.
- Write: on a rising edge with wr[i]=1 and column i not full, store slice i at wrptr[i] and increment wrptr[i]. Wrap-around is natural modulo 2*depth.
- Write to a full column: data is dropped, the pointer is held, and overflow is set. overflow stays 1 until reset.
- Column status: column i is empty when wrptr[i]==rdptr. It is full when the low bits are equal and the wrap bits differ.
- Flags (combinational from pointers): o_valid = AND over columns of not-empty. o_full = OR over columns of full.
- Read: on a rising edge with rd=1 and o_valid=1:
  - out <= the entry at rdptr from every column;
  - rdptr increments;
  - out_valid=1 for exactly the next cycle.
  - Latency is one cycle from rd to out.
- Read with o_valid=0: ignored. out is held and out_valid=0.
- out holds its last value until the next successful pop.
- Simultaneous read and write on the same column in one cycle: both take effect.
  - A write to a column that was full is still dropped in that cycle. Full is evaluated before the pop.
  - A write to an empty column does not make that column readable until the following cycle. o_valid is pointer-based.
- Signed psums are stored and output bit-exact; there is no width conversion.

Optional Feature:
- Macro PSUM_RELU_EN.
- Defined: each popped slice is clamped at output register load; a negative value (MSB=1) becomes 0. Storage is unchanged.
- Undefined: raw signed psums are output.

Decomposition:
- Shared package holds COL_DEFAULT=8, BW_PSUM_DEFAULT=20, FIFO_DEPTH_DEFAULT=16, and a pointer-width function clog2(depth)+1.
- Natural sub-module: psum_col_buf, one column circular buffer. It takes wr, din and the shared rdptr, and outputs empty, full and the dout at rdptr.
- The top instantiates col copies of psum_col_buf. Flag reduction, overflow and the output register stay in the top.

Test Plan:
- Reset mid-stream: write 3 rows, then pull reset low between edges → flags/out/out_valid go to 0 immediately; after release, o_valid=0 and rd is ignored.
- Staggered fill: wr bit i asserted at cycle t+i with in slice i = 100+i → o_valid rises only the cycle after column 7 writes. rd → next cycle out slices = 100..107, out_valid=1 for one cycle.
- Full/overflow: write depth=16 rows to column 0 only → o_full=1, o_valid=0. 17th write to column 0 → overflow=1, column 0 still holds the first 16 values.
- Wrap-around: 40 rows of all-column writes interleaved with pops, values = row index → popped rows read 0..39 in order, no loss, overflow=0.
- Simultaneous: with column 0 full and all columns non-empty, assert rd and wr[0] together → pop succeeds and the write is dropped (overflow=1). Repeat with column 0 at 15 entries → both succeed, count stays 15.
- PSUM_RELU_EN: store slice values -5 and +7 → out reads 0 and 7 with the macro defined, -5 and 7 without it.
